xadc_sample_framer: RTL and testbench

Downstream stage of the XADC DRP-to-AXIS adapter. It consumes the voltage and current sample streams after their async FIFOs, pairs one voltage with one current sample, and serialises each pair into a fixed 7-byte framed byte stream for the host link. It also discards orphaned samples on a pairing timeout and counts them.

---
 rtl/xadc_sample_framer.sv | 221 ++++++++++++++++++++++
 tb/tb_xadc_sample_framer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_sample_framer.sv
// xadc_sample_framer
// Pairs one voltage and one current sample and serialises the pair into a
// 7-byte frame: SYNC, SEQ, V[15:8], V[7:0], I[15:8], I[7:0], CHK.
// CHK is the XOR of SEQ and the four sample bytes. A lone sample that has
// waited too long for its partner is discarded and counted.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   voltage_tdata/tvalid/tready : voltage sample sink (AXI-Stream subset)
//   current_tdata/tvalid/tready : current sample sink (AXI-Stream subset)
//   frame_tdata/tvalid/tready/tlast/tkeep/tid/tdest/tuser : framed byte source
//   dropped_count            : saturating count of samples dropped on timeout
module xadc_sample_framer #(
    parameter int         SAMPLE_WIDTH        = 16,
    parameter logic [7:0] SYNC_BYTE           = 8'hA5,
    parameter int         PAIR_TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] voltage_tdata,
    input  logic                    voltage_tvalid,
    output logic                    voltage_tready,
    input  logic [SAMPLE_WIDTH-1:0] current_tdata,
    input  logic                    current_tvalid,
    output logic                    current_tready,
    output logic [7:0]              frame_tdata,
    output logic                    frame_tvalid,
    input  logic                    frame_tready,
    output logic                    frame_tlast,
    output logic [0:0]              frame_tkeep,
    output logic [0:0]              frame_tid,
    output logic [0:0]              frame_tdest,
    output logic [0:0]              frame_tuser,
    output logic [15:0]             dropped_count
);

    // The timer only has to reach PAIR_TIMEOUT_CYCLES-1.
    localparam int TIMER_W = (PAIR_TIMEOUT_CYCLES > 1) ? $clog2(PAIR_TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((PAIR_TIMEOUT_CYCLES > 0) ? (PAIR_TIMEOUT_CYCLES - 1) : 0);
    localparam bit TIMEOUT_EN = (PAIR_TIMEOUT_CYCLES > 0);
    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Frame checksum: XOR of every byte after SYNC except CHK itself.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0]  seq,
        input logic [15:0] v,
        input logic [15:0] i
    );
        frame_checksum = seq ^ v[15:8] ^ v[7:0] ^ i[15:8] ^ i[7:0];
    endfunction

    // Byte presented on the link for a given position within the frame.
    function automatic logic [7:0] frame_byte(
        input logic [2:0]  idx,
        input logic [7:0]  seq,
        input logic [15:0] v,
        input logic [15:0] i,
        input logic [7:0]  chk
    );
        case (idx)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = seq;
            3'd2:    frame_byte = v[15:8];
            3'd3:    frame_byte = v[7:0];
            3'd4:    frame_byte = i[15:8];
            3'd5:    frame_byte = i[7:0];
            3'd6:    frame_byte = chk;
            default: frame_byte = 8'h00;
        endcase
    endfunction

    state_t               state_q,  state_d;
    logic [2:0]           idx_q,    idx_d;
    logic [7:0]           seq_q,    seq_d;
    logic [TIMER_W-1:0]   timer_q,  timer_d;
    logic [15:0]          v_q,      v_d;
    logic [15:0]          i_q,      i_d;
    logic [7:0]           chk_q,    chk_d;
    logic [7:0]           tdata_q,  tdata_d;
    logic                 tlast_q,  tlast_d;
    logic                 tvalid_q, tvalid_d;
    logic [15:0]          dropped_q, dropped_d;

    logic                 v_rdy_s;
    logic                 c_rdy_s;
    logic                 pair_s;
    logic                 lone_s;
    logic                 timeout_hit_s;
    logic [2:0]           idx_nxt_s;

    // Next-state logic for pairing, timeout handling and byte sequencing.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        seq_d         = seq_q;
        timer_d       = timer_q;
        v_d           = v_q;
        i_d           = i_q;
        chk_d         = chk_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        tvalid_d      = tvalid_q;
        dropped_d     = dropped_q;
        v_rdy_s       = 1'b0;
        c_rdy_s       = 1'b0;
        pair_s        = voltage_tvalid & current_tvalid;
        lone_s        = voltage_tvalid ^ current_tvalid;
        timeout_hit_s = TIMEOUT_EN && lone_s && (timer_q == TIMER_LAST);
        idx_nxt_s     = idx_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                if (pair_s) begin
                    // A pair always wins, even on the cycle a timeout would fire.
                    v_rdy_s  = 1'b1;
                    c_rdy_s  = 1'b1;
                    v_d      = voltage_tdata[15:0];
                    i_d      = current_tdata[15:0];
                    chk_d    = frame_checksum(seq_q, voltage_tdata[15:0], current_tdata[15:0]);
                    timer_d  = '0;
                    idx_d    = 3'd0;
                    tdata_d  = SYNC_BYTE;
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    state_d  = ST_SEND;
                end else if (timeout_hit_s) begin
                    // Pop the orphan out of its FIFO for one cycle.
                    v_rdy_s = voltage_tvalid;
                    c_rdy_s = current_tvalid;
                    timer_d = '0;
                    if (dropped_q != 16'hFFFF) begin
                        dropped_d = dropped_q + 16'd1;
                    end else begin
                        dropped_d = dropped_q;
                    end
                end else if (TIMEOUT_EN && lone_s) begin
                    timer_d = timer_q + TIMER_W'(1);
                end else begin
                    timer_d = '0;
                end
            end
            ST_SEND: begin
                timer_d = '0;
                if (tvalid_q && frame_tready) begin
                    if (idx_q == LAST_IDX) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = 8'h00;
                        seq_d    = seq_q + 8'd1;
                        idx_d    = 3'd0;
                        state_d  = ST_IDLE;
                    end else begin
                        idx_d   = idx_nxt_s;
                        tdata_d = frame_byte(idx_nxt_s, seq_q, v_q, i_q, chk_q);
                        tlast_d = (idx_nxt_s == LAST_IDX);
                    end
                end else begin
                    // Stalled: the registered byte is held as-is.
                    tvalid_d = tvalid_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tdata_d  = 8'h00;
                idx_d    = 3'd0;
                timer_d  = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            seq_q     <= 8'h00;
            timer_q   <= '0;
            v_q       <= 16'h0000;
            i_q       <= 16'h0000;
            chk_q     <= 8'h00;
            tdata_q   <= 8'h00;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            dropped_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            timer_q   <= timer_d;
            v_q       <= v_d;
            i_q       <= i_d;
            chk_q     <= chk_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
            dropped_q <= dropped_d;
        end
    end

    // Sink readies are combinational; held low while reset is asserted.
    assign voltage_tready = v_rdy_s & ~rst;
    assign current_tready = c_rdy_s & ~rst;

    assign frame_tdata   = tdata_q;
    assign frame_tvalid  = tvalid_q;
    assign frame_tlast   = tlast_q;
    assign frame_tkeep   = 1'b1;
    assign frame_tid     = 1'b0;
    assign frame_tdest   = 1'b0;
    assign frame_tuser   = 1'b0;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_xadc_sample_framer.sv
`timescale 1ns/1ps
module tb_xadc_sample_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance (timeout 16)
    logic [15:0] v_tdata = 16'h0000;
    logic        v_tvalid = 1'b0;
    logic        v_tready;
    logic [15:0] c_tdata = 16'h0000;
    logic        c_tvalid = 1'b0;
    logic        c_tready;
    logic [7:0]  f_tdata;
    logic        f_tvalid;
    logic        f_tready = 1'b1;
    logic        f_tlast;
    logic [0:0]  f_tkeep, f_tid, f_tdest, f_tuser;
    logic [15:0] dropped;

    // Saturation instance (timeout 1)
    logic [15:0] s_v_tdata = 16'h0000;
    logic        s_v_tvalid = 1'b0;
    logic        s_v_tready;
    logic        s_c_tready;
    logic [7:0]  s_f_tdata;
    logic        s_f_tvalid;
    logic        s_f_tlast;
    logic [0:0]  s_f_tkeep, s_f_tid, s_f_tdest, s_f_tuser;
    logic [15:0] s_dropped;

    int total = 0;
    int bad   = 0;

    logic [8:0]  exp_q[$];   // {tlast, tdata}
    logic [7:0]  model_seq = 8'h00;
    int          model_drops = 0;
    int          rdy_mode = 0;  // 0 always ready, 1 pattern 1,0,0,1, 2 random
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_word = 9'h000;

    xadc_sample_framer #(.PAIR_TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .voltage_tdata(v_tdata), .voltage_tvalid(v_tvalid), .voltage_tready(v_tready),
        .current_tdata(c_tdata), .current_tvalid(c_tvalid), .current_tready(c_tready),
        .frame_tdata(f_tdata), .frame_tvalid(f_tvalid), .frame_tready(f_tready),
        .frame_tlast(f_tlast), .frame_tkeep(f_tkeep), .frame_tid(f_tid),
        .frame_tdest(f_tdest), .frame_tuser(f_tuser), .dropped_count(dropped)
    );

    xadc_sample_framer #(.PAIR_TIMEOUT_CYCLES(1)) dut_sat (
        .clk(clk), .rst(rst),
        .voltage_tdata(s_v_tdata), .voltage_tvalid(s_v_tvalid), .voltage_tready(s_v_tready),
        .current_tdata(16'h0000), .current_tvalid(1'b0), .current_tready(s_c_tready),
        .frame_tdata(s_f_tdata), .frame_tvalid(s_f_tvalid), .frame_tready(1'b1),
        .frame_tlast(s_f_tlast), .frame_tkeep(s_f_tkeep), .frame_tid(s_f_tid),
        .frame_tdest(s_f_tdest), .frame_tuser(s_f_tuser), .dropped_count(s_dropped)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected frame for an accepted pair, built straight from the frame rules.
    task automatic model_push_frame(input logic [15:0] v, input logic [15:0] i);
        logic [7:0] b [0:6];
        b[0] = 8'hA5;
        b[1] = model_seq;
        b[2] = v[15:8];
        b[3] = v[7:0];
        b[4] = i[15:8];
        b[5] = i[7:0];
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        for (int k = 0; k < 7; k++) exp_q.push_back({(k == 6) ? 1'b1 : 1'b0, b[k]});
        model_seq = model_seq + 8'd1;
    endtask

    // Output monitor: byte stream vs model, hold during stalls, no intake while sending.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", {31'd0, f_tvalid}, 32'd1);
                check_val("stall_word", {23'd0, f_tlast, f_tdata}, {23'd0, prev_word});
            end
            prev_stall = f_tvalid && !f_tready;
            prev_word  = {f_tlast, f_tdata};
            if (f_tvalid)
                check_val("rdy_in_send", {30'd0, v_tready, c_tready}, 32'd0);
            if (f_tvalid && f_tready) begin
                if (exp_q.size() == 0) check_val("unexpected_byte", {23'd0, f_tlast, f_tdata}, 32'hFFFF_FFFF);
                else check_val("frame_byte", {23'd0, f_tlast, f_tdata}, {23'd0, exp_q.pop_front()});
            end
            if (v_tvalid && v_tready && c_tvalid && c_tready) model_push_frame(v_tdata, c_tdata);
        end
    end

    // Downstream ready generator.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin f_tready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
                2: f_tready = 1'($urandom_range(0, 1));
                default: f_tready = 1'b1;
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_pair(input logic [15:0] v, input logic [15:0] i);
        bit ok = 1'b0;
        v_tdata = v; c_tdata = i; v_tvalid = 1'b1; c_tvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (v_tready && c_tready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        v_tvalid = 1'b0; c_tvalid = 1'b0;
        check_val("pair_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !f_tvalid) done = 1'b1;
        end
        check_val("drain", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] t1 [0:6];
        int pulses;
        int pulse_at;
        int busy;
        t1[0] = 8'hA5; t1[1] = 8'h00; t1[2] = 8'h12; t1[3] = 8'h30;
        t1[4] = 8'h0A; t1[5] = 8'hBC; t1[6] = 8'h94;

        // Reset state, with both sinks offering data during reset.
        v_tvalid = 1'b1; c_tvalid = 1'b1;
        #22;
        check_val("rst_tvalid", {31'd0, f_tvalid}, 32'd0);
        check_val("rst_tdata", {24'd0, f_tdata}, 32'd0);
        check_val("rst_tlast", {31'd0, f_tlast}, 32'd0);
        check_val("rst_treadies", {30'd0, v_tready, c_tready}, 32'd0);
        check_val("rst_dropped", {16'd0, dropped}, 32'd0);
        check_val("sideband", {28'd0, f_tkeep, f_tid, f_tdest, f_tuser}, 32'h8);
        v_tvalid = 1'b0; c_tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single pair, always ready, exact bytes on consecutive cycles.
        rdy_mode = 0;
        send_pair(16'h1230, 16'h0ABC);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check_val("t1_valid", {31'd0, f_tvalid}, 32'd1);
            check_val("t1_byte", {23'd0, f_tlast, f_tdata}, {23'd0, (k == 6) ? 1'b1 : 1'b0, t1[k]});
            @(posedge clk); #1;
        end
        wait_idle();

        // 2: stalled downstream, second pair waiting while the first is sent.
        rdy_mode = 1;
        send_pair(16'h1230, 16'h0ABC);
        send_pair(16'hBEEF, 16'h1357);
        wait_idle();
        rdy_mode = 0;

        // 3: lone voltage sample times out once, then pairs at timer=10.
        v_tdata = 16'h0100; v_tvalid = 1'b1;
        pulses = 0; pulse_at = -1; busy = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (v_tready) begin pulses++; if (pulse_at < 0) pulse_at = c; end
            if (f_tvalid || c_tready) busy++;
            @(posedge clk); #1;
        end
        model_drops = 1;
        check_val("t3_pulse_cycle", pulse_at, 32'd15);
        check_val("t3_pulse_count", pulses, 32'd1);
        check_val("t3_no_activity", busy, 32'd0);
        check_val("t3_dropped", {16'd0, dropped}, model_drops);
        c_tdata = 16'h0BAD; c_tvalid = 1'b1;
        @(negedge clk);
        check_val("t3_pair_ready", {30'd0, v_tready, c_tready}, 32'd3);
        @(posedge clk); #1;
        v_tvalid = 1'b0; c_tvalid = 1'b0;
        wait_idle();
        check_val("t3_dropped_after", {16'd0, dropped}, model_drops);

        // 4: 257 random pairs with random backpressure; SEQ wraps.
        rdy_mode = 2;
        for (int p = 0; p < 257; p++) begin
            send_pair(16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_idle();
        rdy_mode = 0;
        @(posedge clk); #1;

        // 5: reset while byte idx 3 is on the link.
        send_pair(16'h4455, 16'h6677);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) begin @(posedge clk); #1; end
        end
        check_val("t5_idx3", {24'd0, f_tdata}, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_async_tvalid", {31'd0, f_tvalid}, 32'd0);
        exp_q.delete();
        model_seq = 8'h00;
        model_drops = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("t5_dropped", {16'd0, dropped}, model_drops);
        send_pair(16'h0001, 16'h0002);
        @(negedge clk);
        check_val("t5_sync", {23'd0, f_tlast, f_tdata}, 32'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("t5_seq", {24'd0, f_tdata}, 32'h00);
        wait_idle();

        // 6: continuous lone samples on the timeout-1 instance saturate the counter.
        s_v_tdata = 16'h00AA; s_v_tvalid = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check_val("t6_pre_sat", {16'd0, s_dropped}, 32'hFFFE);
        @(posedge clk);
        @(negedge clk);
        check_val("t6_sat", {16'd0, s_dropped}, 32'hFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("t6_hold_sat", {16'd0, s_dropped}, 32'hFFFF);
        check_val("t6_still_dropping", {31'd0, s_v_tready}, 32'd1);
        check_val("t6_no_frame", {31'd0, s_f_tvalid}, 32'd0);
        s_v_tvalid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
